stack_mem_unit: RTL and testbench

- Memory-stage datapath that consumes the stack sequencer's phase and selector outputs plus MR/MW.
- Owns the stack pointer SP and drives data-memory address, write data and enables for single and multi-word accesses.
- Reassembles popped PC and flags for RET/RTI; sits between the stack sequencer and synchronous data memory.
- Memory has 1-cycle read latency.

---
 rtl/stack_mem_unit_if.sv | 29 ++
 rtl/stack_mem_unit.sv | 212 +++++++++++++++++++++
 tb/tb_stack_mem_unit.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_mem_unit_if.sv
`timescale 1ns/1ps
// Data-memory bus between the stack memory unit (master) and a synchronous
// single-port data memory with one cycle of read latency (slave).
interface stack_mem_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [DATA_WIDTH-1:0] Mem_Wdata;
  logic                  Mem_WE;
  logic                  Mem_RE;
  logic [DATA_WIDTH-1:0] Mem_Rdata;

  modport master (
    output Mem_Addr,
    output Mem_Wdata,
    output Mem_WE,
    output Mem_RE,
    input  Mem_Rdata
  );

  modport slave (
    input  Mem_Addr,
    input  Mem_Wdata,
    input  Mem_WE,
    input  Mem_RE,
    output Mem_Rdata
  );
endinterface

// File: rtl/stack_mem_unit.sv
`timescale 1ns/1ps
// Memory-stage stack datapath: owns SP, steers the data-memory bus for single
// and multi-word pushes/pops, and reassembles popped PC/flags for RET/RTI.
module stack_mem_unit #(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 12,
  parameter int unsigned SP_INIT    = (32'd1 << ADDR_WIDTH) - 32'd1,
  parameter int          FLAG_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Is_Stack,
  input  logic                  MR,
  input  logic                  MW,
  input  logic [1:0]            State_Machine_Out,
  input  logic [1:0]            Machine_Stack,
  input  logic [31:0]           PC,
  input  logic [FLAG_WIDTH-1:0] Flags,
  input  logic [ADDR_WIDTH-1:0] Eff_Addr,
  input  logic [DATA_WIDTH-1:0] Wr_Data,
  stack_mem_unit_if.master      mem,
  output logic [ADDR_WIDTH-1:0] SP,
  output logic [31:0]           Ret_PC,
  output logic                  Ret_PC_Valid,
  output logic [FLAG_WIDTH-1:0] Ret_Flags,
  output logic                  Ret_Flags_Valid,
  output logic                  Stack_Err
);

  localparam logic [ADDR_WIDTH-1:0] SP_TOP = ADDR_WIDTH'(SP_INIT);
  localparam logic [ADDR_WIDTH-1:0] SP_ONE = ADDR_WIDTH'(1);

  localparam logic [1:0] PH_SINGLE = 2'b00;
  localparam logic [1:0] PH_WORD1  = 2'b01;
  localparam logic [1:0] PH_WORD2  = 2'b10;
  localparam logic [1:0] PH_WORD3  = 2'b11;

  localparam logic [1:0] MS_NONE     = 2'b00;
  localparam logic [1:0] MS_PC       = 2'b01;
  localparam logic [1:0] MS_FLAGS    = 2'b10;
  localparam logic [1:0] MS_PC_FLAGS = 2'b11;

  // Which Ret slice the word returning from memory next cycle belongs to.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'b00,
    TAG_PC_LO = 2'b01,
    TAG_PC_HI = 2'b10,
    TAG_FLAGS = 2'b11
  } cap_tag_e;

  logic illegal;
  logic stack_push;
  logic stack_pop;
  logic overflow;
  logic underflow;
  logic multi_word;

  logic [DATA_WIDTH-1:0] push_word;
  cap_tag_e              pop_tag;
  logic                  pop_last;

  cap_tag_e cap_tag;
  logic     cap_last;
  logic     flags_seen;

  assign illegal    = MR & MW;
  assign stack_push = Is_Stack & MW & ~MR;
  assign stack_pop  = Is_Stack & MR & ~MW;
  assign overflow   = stack_push & (SP == '0);
  assign underflow  = stack_pop & (SP == SP_TOP);
  assign multi_word = (State_Machine_Out != PH_SINGLE) && (Machine_Stack != MS_NONE);

  // Push order is PC_hi, PC_lo, flags; anything outside a defined slot
  // falls back to a plain single-word write of Wr_Data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    push_word = Wr_Data;
    if (multi_word) begin
      case (Machine_Stack)
        MS_PC: begin
          if (State_Machine_Out == PH_WORD1)      push_word = DATA_WIDTH'(PC[31:16]);
          else if (State_Machine_Out == PH_WORD2) push_word = DATA_WIDTH'(PC[15:0]);
        end
        MS_FLAGS: begin
          if (State_Machine_Out == PH_WORD1) push_word = DATA_WIDTH'(Flags);
        end
        MS_PC_FLAGS: begin
          case (State_Machine_Out)
            PH_WORD1: push_word = DATA_WIDTH'(PC[31:16]);
            PH_WORD2: push_word = DATA_WIDTH'(PC[15:0]);
            PH_WORD3: push_word = DATA_WIDTH'(Flags);
            default:  push_word = Wr_Data;
          endcase
        end
        default: push_word = Wr_Data;
      endcase
    end
  end

  // Pops come back in reverse push order; pop_last marks the read that
  // completes the sequence and therefore earns the Valid pulse.
  always_comb begin
    pop_tag  = TAG_NONE;
    pop_last = 1'b0;
    if (multi_word) begin
      case (Machine_Stack)
        MS_PC: begin
          if (State_Machine_Out == PH_WORD1) begin
            pop_tag = TAG_PC_LO;
          end else if (State_Machine_Out == PH_WORD2) begin
            pop_tag  = TAG_PC_HI;
            pop_last = 1'b1;
          end
        end
        MS_FLAGS: begin
          if (State_Machine_Out == PH_WORD1) begin
            pop_tag  = TAG_FLAGS;
            pop_last = 1'b1;
          end
        end
        MS_PC_FLAGS: begin
          case (State_Machine_Out)
            PH_WORD1: pop_tag = TAG_FLAGS;
            PH_WORD2: pop_tag = TAG_PC_LO;
            PH_WORD3: begin
              pop_tag  = TAG_PC_HI;
              pop_last = 1'b1;
            end
            default: pop_tag = TAG_NONE;
          endcase
        end
        default: pop_tag = TAG_NONE;
      endcase
    end
  end

  // The bus idles at all-zero unless a legal read or write is requested.
  always_comb begin
    mem.Mem_Addr  = '0;
    mem.Mem_Wdata = '0;
    mem.Mem_WE    = 1'b0;
    mem.Mem_RE    = 1'b0;
    if (!illegal) begin
      if (!Is_Stack) begin
        if (MR || MW) begin
          mem.Mem_Addr  = Eff_Addr;
          mem.Mem_Wdata = Wr_Data;
          mem.Mem_WE    = MW;
          mem.Mem_RE    = MR;
        end
      end else if (stack_push) begin
        mem.Mem_Addr  = SP;
        mem.Mem_Wdata = push_word;
        mem.Mem_WE    = ~overflow;
      end else if (stack_pop) begin
        mem.Mem_Addr = SP + SP_ONE;
        mem.Mem_RE   = ~underflow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      SP              <= SP_TOP;
      Ret_PC          <= '0;
      Ret_PC_Valid    <= 1'b0;
      Ret_Flags       <= '0;
      Ret_Flags_Valid <= 1'b0;
      Stack_Err       <= 1'b0;
      cap_tag         <= TAG_NONE;
      cap_last        <= 1'b0;
      flags_seen      <= 1'b0;
    end else begin
      if (stack_push) begin
        if (overflow) Stack_Err <= 1'b1;
        else          SP        <= SP - SP_ONE;
      end else if (stack_pop) begin
        if (underflow) Stack_Err <= 1'b1;
        else           SP        <= SP + SP_ONE;
      end

      // A suppressed read returns nothing, so it carries no tag; that alone
      // keeps an underflowed sequence from ever reaching its Valid pulse.
      if (stack_pop && !underflow) begin
        cap_tag  <= pop_tag;
        cap_last <= pop_last;
      end else begin
        cap_tag  <= TAG_NONE;
        cap_last <= 1'b0;
      end

      case (cap_tag)
        TAG_PC_LO: Ret_PC[15:0]  <= Mem_Rdata_lo();
        TAG_PC_HI: Ret_PC[31:16] <= Mem_Rdata_lo();
        TAG_FLAGS: Ret_Flags     <= mem.Mem_Rdata[FLAG_WIDTH-1:0];
        default:   ;
      endcase

      Ret_PC_Valid    <= cap_last && (cap_tag == TAG_PC_HI);
      Ret_Flags_Valid <= cap_last && ((cap_tag == TAG_FLAGS) || flags_seen);

      if (underflow || cap_last)     flags_seen <= 1'b0;
      else if (cap_tag == TAG_FLAGS) flags_seen <= 1'b1;
    end
  end

  function automatic logic [15:0] Mem_Rdata_lo();
    return mem.Mem_Rdata[15:0];
  endfunction

endmodule

// File: tb/tb_stack_mem_unit.sv
`timescale 1ns/1ps
// Self-checking bench for stack_mem_unit: a sequence-level model of the stack
// is compared against the DUT every cycle, plus literal spot checks.
module tb_stack_mem_unit;
  localparam int DW     = 16;
  localparam int AW     = 12;
  localparam int FW     = 3;
  localparam int SP_TOP = 4095;

  logic          clk = 1'b0;
  logic          rst;
  logic          Is_Stack, MR, MW;
  logic [1:0]    State_Machine_Out, Machine_Stack;
  logic [31:0]   PC;
  logic [FW-1:0] Flags;
  logic [AW-1:0] Eff_Addr;
  logic [DW-1:0] Wr_Data;
  logic [AW-1:0] SP;
  logic [31:0]   Ret_PC;
  logic          Ret_PC_Valid;
  logic [FW-1:0] Ret_Flags;
  logic          Ret_Flags_Valid;
  logic          Stack_Err;

  stack_mem_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  stack_mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLAG_WIDTH(FW)) dut (
    .clk               (clk),
    .rst               (rst),
    .Is_Stack          (Is_Stack),
    .MR                (MR),
    .MW                (MW),
    .State_Machine_Out (State_Machine_Out),
    .Machine_Stack     (Machine_Stack),
    .PC                (PC),
    .Flags             (Flags),
    .Eff_Addr          (Eff_Addr),
    .Wr_Data           (Wr_Data),
    .mem               (bus),
    .SP                (SP),
    .Ret_PC            (Ret_PC),
    .Ret_PC_Valid      (Ret_PC_Valid),
    .Ret_Flags         (Ret_Flags),
    .Ret_Flags_Valid   (Ret_Flags_Valid),
    .Stack_Err         (Stack_Err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous data memory, one cycle read latency; idle reads return a marker.
  logic [DW-1:0] mem_array [0:4095];
  always @(posedge clk) begin
    if (bus.Mem_WE) mem_array[bus.Mem_Addr] <= bus.Mem_Wdata;
    bus.Mem_Rdata <= bus.Mem_RE ? mem_array[bus.Mem_Addr] : 16'hDEAD;
  end

  // ---------------- reference model ----------------
  typedef enum int {EV_LO, EV_HI, EV_FL, EV_PCV, EV_FLV} ev_kind_e;
  typedef struct {
    int          due;
    ev_kind_e    kind;
    logic [15:0] val;
  } ev_t;

  ev_t         pend[$];
  int          m_sp;
  bit          m_err;
  int          cyc = 0;
  logic [15:0] shadow [0:4095];
  logic [31:0] e_ret_pc;
  logic [2:0]  e_ret_fl;
  bit          e_pcv, e_flv;

  // Words of a multi-word frame, in push order: PC_hi, PC_lo, flags.
  function automatic int seq_len(input logic [1:0] ms);
    case (ms)
      2'b01:   return 2;
      2'b10:   return 1;
      2'b11:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic ev_kind_e seq_role(input logic [1:0] ms, input int pos);
    if (ms == 2'b10) return EV_FL;
    if (pos == 0) return EV_HI;
    if (pos == 1) return EV_LO;
    return EV_FL;
  endfunction

  function automatic logic [15:0] exp_push_word();
    int n = seq_len(Machine_Stack);
    int k = int'(State_Machine_Out);
    if (k == 0 || k > n) return Wr_Data;
    case (seq_role(Machine_Stack, k - 1))
      EV_HI:   return PC[31:16];
      EV_LO:   return PC[15:0];
      default: return {13'd0, Flags};
    endcase
  endfunction

  task automatic model_reset();
    m_sp     = SP_TOP;
    m_err    = 1'b0;
    e_ret_pc = '0;
    e_ret_fl = '0;
    e_pcv    = 1'b0;
    e_flv    = 1'b0;
    pend.delete();
  endtask

  task automatic model_edge();
    int          n, k;
    logic [15:0] w;
    ev_t         keep[$];
    if (!(MR && MW) && Is_Stack && MW) begin
      if (m_sp == 0) m_err = 1'b1;
      else begin
        shadow[m_sp] = exp_push_word();
        m_sp--;
      end
    end else if (!(MR && MW) && Is_Stack && MR) begin
      if (m_sp == SP_TOP) m_err = 1'b1;
      else begin
        m_sp++;
        w = shadow[m_sp];
        n = seq_len(Machine_Stack);
        k = int'(State_Machine_Out);
        if (k > 0 && k <= n) begin
          pend.push_back('{due: cyc + 2, kind: seq_role(Machine_Stack, n - k), val: w});
          if (k == n) begin
            if (Machine_Stack[0]) pend.push_back('{due: cyc + 2, kind: EV_PCV, val: 16'h0});
            if (Machine_Stack[1]) pend.push_back('{due: cyc + 2, kind: EV_FLV, val: 16'h0});
          end
        end
      end
    end
    cyc++;
    e_pcv = 1'b0;
    e_flv = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        case (pend[i].kind)
          EV_LO:   e_ret_pc[15:0]  = pend[i].val;
          EV_HI:   e_ret_pc[31:16] = pend[i].val;
          EV_FL:   e_ret_fl        = pend[i].val[2:0];
          EV_PCV:  e_pcv           = 1'b1;
          default: e_flv           = 1'b1;
        endcase
      end else begin
        keep.push_back(pend[i]);
      end
    end
    pend = keep;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_edge();
  end

  task automatic compare_outputs();
    bit            ill;
    logic [AW-1:0] ea;
    ill = MR && MW;
    check("mem_we", 32'(bus.Mem_WE), 32'(!ill && MW && (!Is_Stack || m_sp != 0)));
    check("mem_re", 32'(bus.Mem_RE), 32'(!ill && MR && (!Is_Stack || m_sp != SP_TOP)));
    if (!ill && (MR || MW)) begin
      ea = Is_Stack ? (MW ? AW'(m_sp) : AW'(m_sp + 1)) : Eff_Addr;
      check("mem_addr", 32'(bus.Mem_Addr), 32'(ea));
    end
    if (!Is_Stack && !MR && !MW) begin
      check("idle_addr", 32'(bus.Mem_Addr), 32'h0);
      check("idle_wdata", 32'(bus.Mem_Wdata), 32'h0);
    end
    if (!ill && MW)
      check("mem_wdata", 32'(bus.Mem_Wdata), 32'(Is_Stack ? exp_push_word() : Wr_Data));
    check("sp", 32'(SP), 32'(m_sp));
    check("stack_err", 32'(Stack_Err), 32'(m_err));
    check("ret_pc", Ret_PC, e_ret_pc);
    check("ret_flags", 32'(Ret_Flags), 32'(e_ret_fl));
    check("ret_pc_valid", 32'(Ret_PC_Valid), 32'(e_pcv));
    check("ret_flags_valid", 32'(Ret_Flags_Valid), 32'(e_flv));
  endtask

  always @(negedge clk) if (cmp_en && rst === 1'b1) compare_outputs();

  // ---------------- stimulus ----------------
  task automatic set_in(input bit st, input bit mr, input bit mw,
                        input logic [1:0] ph, input logic [1:0] ms);
    Is_Stack          = st;
    MR                = mr;
    MW                = mw;
    State_Machine_Out = ph;
    Machine_Stack     = ms;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_array[i] = '0;
      shadow[i]    = '0;
    end
    rst = 1'b1;
    set_in(0, 0, 0, 2'b00, 2'b00);
    PC = '0; Flags = '0; Eff_Addr = '0; Wr_Data = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_sp", 32'(SP), 32'hFFF);
    check("rst_err", 32'(Stack_Err), 32'h0);
    check("rst_pcv", 32'(Ret_PC_Valid), 32'h0);
    check("rst_flv", 32'(Ret_Flags_Valid), 32'h0);
    check("rst_ret_pc", Ret_PC, 32'h0);
    check("rst_idle_en", 32'({bus.Mem_WE, bus.Mem_RE}), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Push PC+flags frame
    PC = 32'h0001_2345; Flags = 3'b101;
    set_in(1, 0, 1, 2'b01, 2'b11); mid();
    check("push1_addr", 32'(bus.Mem_Addr), 32'hFFF);
    check("push1_data", 32'(bus.Mem_Wdata), 32'h0001);
    check("push1_we", 32'(bus.Mem_WE), 32'h1);
    tick();
    set_in(1, 0, 1, 2'b10, 2'b11); mid();
    check("push2_addr", 32'(bus.Mem_Addr), 32'hFFE);
    check("push2_data", 32'(bus.Mem_Wdata), 32'h2345);
    tick();
    set_in(1, 0, 1, 2'b11, 2'b11); mid();
    check("push3_addr", 32'(bus.Mem_Addr), 32'hFFD);
    check("push3_data", 32'(bus.Mem_Wdata), 32'h0005);
    tick();
    set_in(0, 0, 0, 2'b00, 2'b00); mid();
    check("push_sp", 32'(SP), 32'hFFC);
    check("mem_fff", 32'(mem_array[12'hFFF]), 32'h0001);
    check("mem_ffe", 32'(mem_array[12'hFFE]), 32'h2345);
    check("mem_ffd", 32'(mem_array[12'hFFD]), 32'h0005);
    tick();

    // Pop PC+flags frame
    set_in(1, 1, 0, 2'b01, 2'b11); mid();
    check("pop1_addr", 32'(bus.Mem_Addr), 32'hFFD);
    check("pop1_re", 32'(bus.Mem_RE), 32'h1);
    tick();
    set_in(1, 1, 0, 2'b10, 2'b11); mid();
    check("pop2_addr", 32'(bus.Mem_Addr), 32'hFFE);
    tick();
    set_in(1, 1, 0, 2'b11, 2'b11); mid();
    check("pop3_addr", 32'(bus.Mem_Addr), 32'hFFF);
    tick();
    set_in(0, 0, 0, 2'b00, 2'b00); mid();
    check("pop_n1_pcv", 32'(Ret_PC_Valid), 32'h0);
    check("pop_n1_flv", 32'(Ret_Flags_Valid), 32'h0);
    tick(); mid();
    check("pop_n2_pc", Ret_PC, 32'h0001_2345);
    check("pop_n2_pcv", 32'(Ret_PC_Valid), 32'h1);
    check("pop_n2_flags", 32'(Ret_Flags), 32'h5);
    check("pop_n2_flv", 32'(Ret_Flags_Valid), 32'h1);
    check("pop_sp", 32'(SP), 32'hFFF);
    tick(); mid();
    check("pop_n3_pcv", 32'(Ret_PC_Valid), 32'h0);
    check("pop_n3_flv", 32'(Ret_Flags_Valid), 32'h0);
    tick();

    // Single push / pop
    Wr_Data = 16'hBEEF;
    set_in(1, 0, 1, 2'b00, 2'b00); mid();
    check("single_push_addr", 32'(bus.Mem_Addr), 32'hFFF);
    check("single_push_data", 32'(bus.Mem_Wdata), 32'hBEEF);
    tick();
    set_in(1, 1, 0, 2'b00, 2'b00); mid();
    check("single_push_sp", 32'(SP), 32'hFFE);
    check("single_pop_addr", 32'(bus.Mem_Addr), 32'hFFF);
    tick();
    set_in(0, 0, 0, 2'b00, 2'b00); mid();
    check("single_pop_rdata", 32'(bus.Mem_Rdata), 32'hBEEF);
    check("single_pop_sp", 32'(SP), 32'hFFF);
    tick(); mid();
    check("single_pop_pcv", 32'(Ret_PC_Valid), 32'h0);
    check("single_pop_flv", 32'(Ret_Flags_Valid), 32'h0);
    tick();

    // PC-only frame
    PC = 32'hCAFE_1234;
    set_in(1, 0, 1, 2'b01, 2'b01); tick();
    set_in(1, 0, 1, 2'b10, 2'b01); tick();
    set_in(1, 1, 0, 2'b01, 2'b01); tick();
    set_in(1, 1, 0, 2'b10, 2'b01); tick();
    set_in(0, 0, 0, 2'b00, 2'b00); tick(); mid();
    check("pc_only_pc", Ret_PC, 32'hCAFE_1234);
    check("pc_only_pcv", 32'(Ret_PC_Valid), 32'h1);
    check("pc_only_flv", 32'(Ret_Flags_Valid), 32'h0);
    check("pc_only_flags_hold", 32'(Ret_Flags), 32'h5);
    tick();

    // Flags-only frame
    Flags = 3'b010;
    set_in(1, 0, 1, 2'b01, 2'b10); tick();
    set_in(1, 1, 0, 2'b01, 2'b10); tick();
    set_in(0, 0, 0, 2'b00, 2'b00); tick(); mid();
    check("fl_only_flags", 32'(Ret_Flags), 32'h2);
    check("fl_only_flv", 32'(Ret_Flags_Valid), 32'h1);
    check("fl_only_pcv", 32'(Ret_PC_Valid), 32'h0);
    check("fl_only_pc_hold", Ret_PC, 32'hCAFE_1234);
    tick();

    // Non-stack store and load
    Eff_Addr = 12'h123; Wr_Data = 16'h00AA;
    set_in(0, 0, 1, 2'b00, 2'b00); mid();
    check("std_addr", 32'(bus.Mem_Addr), 32'h123);
    check("std_we", 32'(bus.Mem_WE), 32'h1);
    check("std_re", 32'(bus.Mem_RE), 32'h0);
    tick();
    set_in(0, 1, 0, 2'b00, 2'b00); mid();
    check("std_sp", 32'(SP), 32'hFFF);
    check("ldd_re", 32'(bus.Mem_RE), 32'h1);
    tick();
    set_in(0, 0, 0, 2'b00, 2'b00); mid();
    check("ldd_rdata", 32'(bus.Mem_Rdata), 32'h00AA);
    tick();

    // Illegal MR=MW=1
    set_in(1, 1, 1, 2'b00, 2'b00); mid();
    check("illegal_en", 32'({bus.Mem_WE, bus.Mem_RE}), 32'h0);
    tick();
    set_in(0, 1, 1, 2'b00, 2'b00); mid();
    check("illegal_sp", 32'(SP), 32'hFFF);
    check("illegal_err", 32'(Stack_Err), 32'h0);
    tick();

    // Underflow
    set_in(1, 1, 0, 2'b00, 2'b00); mid();
    check("uflow_re", 32'(bus.Mem_RE), 32'h0);
    tick();
    set_in(0, 0, 0, 2'b00, 2'b00); mid();
    check("uflow_sp", 32'(SP), 32'hFFF);
    check("uflow_err", 32'(Stack_Err), 32'h1);
    repeat (3) tick();
    mid();
    check("uflow_err_sticky", 32'(Stack_Err), 32'h1);
    tick();

    // Reset in the middle of a PC pop sequence
    PC = 32'h1111_2222;
    set_in(1, 0, 1, 2'b01, 2'b01); tick();
    set_in(1, 0, 1, 2'b10, 2'b01); tick();
    set_in(1, 1, 0, 2'b01, 2'b01); tick();
    set_in(1, 1, 0, 2'b10, 2'b01);
    #2 rst = 1'b0;
    #1;
    check("arst_sp", 32'(SP), 32'hFFF);
    check("arst_err", 32'(Stack_Err), 32'h0);
    check("arst_pcv", 32'(Ret_PC_Valid), 32'h0);
    check("arst_ret_pc", Ret_PC, 32'h0);
    set_in(0, 0, 0, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    mid();
    check("arst_no_pulse", 32'({Ret_PC_Valid, Ret_Flags_Valid}), 32'h0);
    tick();

    // Overflow: fill the whole stack, then one more push
    for (int i = 0; i < 4095; i++) begin
      Wr_Data = 16'(i);
      set_in(1, 0, 1, 2'b00, 2'b00);
      tick();
    end
    Wr_Data = 16'h5555;
    mid();
    check("full_sp", 32'(SP), 32'h000);
    check("oflow_we", 32'(bus.Mem_WE), 32'h0);
    tick();
    set_in(1, 1, 0, 2'b00, 2'b00); mid();
    check("oflow_sp", 32'(SP), 32'h000);
    check("oflow_err", 32'(Stack_Err), 32'h1);
    check("oflow_pop_addr", 32'(bus.Mem_Addr), 32'h001);
    tick();
    set_in(0, 0, 0, 2'b00, 2'b00); mid();
    check("oflow_pop_rdata", 32'(bus.Mem_Rdata), 32'h0FFE);
    check("oflow_pop_sp", 32'(SP), 32'h001);
    tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
